// File: rtl/inst_dispatch_pkg.sv
// rtl/inst_dispatch_pkg.sv - opcode constants, FSM state encoding and field helpers for inst_dispatch
package inst_dispatch_pkg;

  localparam logic [31:0] OP_COMP    = '0;
  localparam logic [31:0] OP_BARRIER = '1;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  function automatic int wb_flag_bit(input int op_w, input int num_load);
    return op_w + num_load;
  endfunction

endpackage

// File: rtl/inst_dispatch_if.sv
// rtl/inst_dispatch_if.sv - FIFO head, unit-status and issue signals between dispatcher and accelerator
interface inst_dispatch_if #(
  parameter int NUM_LOAD = 3,
  parameter int INST_LEN = 220,
  parameter int OP_W     = 4,
  parameter int SEL_W    = $clog2(NUM_LOAD + 1)
);

  logic [INST_LEN-1:0]      instruct;
  logic                     inst_empty;
  logic                     inst_req;
  logic                     comp_idle;
  logic                     wb_idle;
  logic [NUM_LOAD-1:0]      ld_idle;
  logic                     comp_conf;
  logic [NUM_LOAD-1:0]      ld_conf;
  logic [INST_LEN-OP_W-1:0] payload;
  logic [SEL_W-1:0]         mig_sel;
  logic                     err_illegal;
  logic                     busy;

  modport master (
    input  instruct, inst_empty, comp_idle, wb_idle, ld_idle,
    output inst_req, comp_conf, ld_conf, payload, mig_sel, err_illegal, busy
  );

  modport slave (
    output instruct, inst_empty, comp_idle, wb_idle, ld_idle,
    input  inst_req, comp_conf, ld_conf, payload, mig_sel, err_illegal, busy
  );

endinterface

// File: rtl/inst_ready_decode.sv
// rtl/inst_ready_decode.sv - combinational opcode decode and target readiness for the FIFO head word
module inst_ready_decode
  import inst_dispatch_pkg::*;
#(
  parameter int NUM_LOAD    = 3,
  parameter int OP_W        = 4,
  parameter int SERIAL_LOAD = 1,
  parameter int SEL_W       = $clog2(NUM_LOAD + 1),
  parameter int WBF         = wb_flag_bit(OP_W, NUM_LOAD)
) (
  input  logic [WBF:0]         head_i,
  input  logic                 comp_idle_i,
  input  logic                 wb_idle_i,
  input  logic [NUM_LOAD-1:0]  ld_idle_i,
  output logic                 ready_o,
  output logic                 is_comp_o,
  output logic                 is_load_o,
  output logic                 is_illegal_o,
  output logic [NUM_LOAD-1:0]  ld_onehot_o,
  output logic [SEL_W-1:0]     ld_sel_o
);

  localparam logic [OP_W-1:0] OPC_COMP = OP_COMP[OP_W-1:0];
  localparam logic [OP_W-1:0] OPC_BAR  = OP_BARRIER[OP_W-1:0];

  logic [OP_W-1:0]     op;
  logic [NUM_LOAD-1:0] dep;
  logic                wb_flag;
  logic                all_ld_idle;
  logic                is_bar;

  assign op          = head_i[OP_W-1:0];
  assign dep         = head_i[OP_W +: NUM_LOAD];
  assign wb_flag     = head_i[WBF];
  assign all_ld_idle = &ld_idle_i;

  always_comb begin
    ld_onehot_o = '0;
    ld_sel_o    = '0;
    for (int i = 0; i < NUM_LOAD; i++) begin
      if (op == OP_W'(i + 1)) begin
        ld_onehot_o[i] = 1'b1;
        ld_sel_o       = SEL_W'(i + 1);
      end
    end
    is_load_o    = |ld_onehot_o;
    is_comp_o    = (op == OPC_COMP);
    is_bar       = (op == OPC_BAR);
    is_illegal_o = !(is_comp_o || is_load_o || is_bar);

    // illegal opcodes are always ready so they get popped and flagged
    ready_o = 1'b1;
    if (is_comp_o) begin
      ready_o = comp_idle_i && (!wb_flag || wb_idle_i) && ((dep & ~ld_idle_i) == '0);
    end else if (is_load_o) begin
      ready_o = ((ld_onehot_o & ld_idle_i) != '0) && ((SERIAL_LOAD == 0) || all_ld_idle);
    end else if (is_bar) begin
      ready_o = comp_idle_i && wb_idle_i && all_ld_idle;
    end
  end

endmodule

// File: rtl/inst_dispatch.sv
// rtl/inst_dispatch.sv - instruction dispatcher: WAIT/ISSUE/GAP FSM issuing compute and load configuration pulses
// Optional performance counters are enabled with INST_DISPATCH_PERF_EN.
module inst_dispatch
  import inst_dispatch_pkg::*;
#(
  parameter int NUM_LOAD    = 3,
  parameter int INST_LEN    = 220,
  parameter int OP_W        = 4,
  parameter int SERIAL_LOAD = 1,
  parameter int SEL_W       = $clog2(NUM_LOAD + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inst_dispatch_if.master      bus
`ifdef INST_DISPATCH_PERF_EN
  ,
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_stall,
  output logic [31:0]          perf_empty
`endif
);

  localparam int WBF = wb_flag_bit(OP_W, NUM_LOAD);

  state_e                   state_q;
  logic                     inst_req_q;
  logic                     comp_conf_q;
  logic [NUM_LOAD-1:0]      ld_conf_q;
  logic [INST_LEN-OP_W-1:0] payload_q;
  logic [SEL_W-1:0]         mig_sel_q;
  logic                     err_q;

  logic                     head_ready;
  logic                     is_comp;
  logic                     is_load;
  logic                     is_illegal;
  logic [NUM_LOAD-1:0]      ld_onehot;
  logic [SEL_W-1:0]         ld_sel;
  logic                     issue_go;

  inst_ready_decode #(
    .NUM_LOAD    (NUM_LOAD),
    .OP_W        (OP_W),
    .SERIAL_LOAD (SERIAL_LOAD),
    .SEL_W       (SEL_W),
    .WBF         (WBF)
  ) u_decode (
    .head_i       (bus.instruct[WBF:0]),
    .comp_idle_i  (bus.comp_idle),
    .wb_idle_i    (bus.wb_idle),
    .ld_idle_i    (bus.ld_idle),
    .ready_o      (head_ready),
    .is_comp_o    (is_comp),
    .is_load_o    (is_load),
    .is_illegal_o (is_illegal),
    .ld_onehot_o  (ld_onehot),
    .ld_sel_o     (ld_sel)
  );

  assign issue_go = (state_q == S_WAIT) && !bus.inst_empty && head_ready;

  // GAP gives the FIFO head and the target's idle one cycle to react before the next check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_WAIT;
      inst_req_q  <= 1'b0;
      comp_conf_q <= 1'b0;
      ld_conf_q   <= '0;
      payload_q   <= '0;
      mig_sel_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      inst_req_q  <= 1'b0;
      comp_conf_q <= 1'b0;
      ld_conf_q   <= '0;
      case (state_q)
        S_WAIT: begin
          if (issue_go) begin
            state_q     <= S_ISSUE;
            inst_req_q  <= 1'b1;
            comp_conf_q <= is_comp;
            ld_conf_q   <= ld_onehot;
            payload_q   <= bus.instruct[INST_LEN-1:OP_W];
            if (is_load)    mig_sel_q <= ld_sel;
            if (is_illegal) err_q     <= 1'b1;
          end
        end
        S_ISSUE: state_q <= S_GAP;
        S_GAP:   state_q <= S_WAIT;
        default: state_q <= S_WAIT;
      endcase
    end
  end

  assign bus.inst_req    = inst_req_q;
  assign bus.comp_conf   = comp_conf_q;
  assign bus.ld_conf     = ld_conf_q;
  assign bus.payload     = payload_q;
  assign bus.mig_sel     = mig_sel_q;
  assign bus.err_illegal = err_q;
  assign bus.busy        = (state_q != S_WAIT) || !bus.inst_empty;

`ifdef INST_DISPATCH_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q,  perf_stall_d;
  logic [31:0] perf_empty_q,  perf_empty_d;

  always_comb begin
    perf_issued_d = perf_issued_q + {31'd0, (state_q == S_ISSUE)};
    perf_stall_d  = perf_stall_q  + {31'd0, (state_q == S_WAIT) && !bus.inst_empty && !head_ready};
    perf_empty_d  = perf_empty_q  + {31'd0, (state_q == S_WAIT) && bus.inst_empty};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
      perf_empty_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
      perf_empty_q  <= perf_empty_d;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
  assign perf_empty  = perf_empty_q;
`endif

endmodule

// File: tb/tb_inst_dispatch.sv
// tb/tb_inst_dispatch.sv - directed bench for inst_dispatch with a cycle-level reference model
module tb_inst_dispatch;

  localparam int NUM_LOAD    = 3;
  localparam int INST_LEN    = 220;
  localparam int OP_W        = 4;
  localparam int SERIAL_LOAD = 1;
  localparam int SEL_W       = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_dispatch_if #(.NUM_LOAD(NUM_LOAD), .INST_LEN(INST_LEN), .OP_W(OP_W), .SEL_W(SEL_W)) bus_if ();

`ifdef INST_DISPATCH_PERF_EN
  logic [31:0] perf_issued, perf_stall, perf_empty;
`endif

  inst_dispatch #(
    .NUM_LOAD(NUM_LOAD), .INST_LEN(INST_LEN), .OP_W(OP_W), .SERIAL_LOAD(SERIAL_LOAD), .SEL_W(SEL_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
`ifdef INST_DISPATCH_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall),
    .perf_empty  (perf_empty)
`endif
  );

  // instruction FIFO: first-word-fall-through head at rd_ptr
  logic [INST_LEN-1:0] fifo_mem [0:15];
  int rd_ptr = 0;
  int wr_ptr = 0;
  assign bus_if.instruct   = fifo_mem[rd_ptr[3:0]];
  assign bus_if.inst_empty = (rd_ptr == wr_ptr);

  int n_checks = 0;
  int n_fail   = 0;
  int req_count  = 0;
  int comp_count = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // spec readiness rules expressed directly on the fields
  function automatic bit model_ready(logic [INST_LEN-1:0] w, bit ci, bit wi, logic [2:0] li);
    int opc;
    logic [2:0] dep;
    opc = int'(w[3:0]);
    dep = w[6:4];
    if (opc == 0)  return ci && (!w[7] || wi) && ((dep & ~li) == 3'b000);
    if (opc >= 1 && opc <= NUM_LOAD) return (SERIAL_LOAD != 0) ? (li == 3'b111) : li[opc-1];
    if (opc == 15) return ci && wi && (li == 3'b111);
    return 1'b1;
  endfunction

  logic                     exp_req = 1'b0;
  logic                     exp_comp = 1'b0;
  logic [2:0]               exp_ld = '0;
  logic [SEL_W-1:0]         exp_mig = '0;
  logic [INST_LEN-OP_W-1:0] exp_payload = '0;
  logic                     exp_err = 1'b0;
  int                       edge_cnt = 0;
  int                       hold_until = 0;

  // model: a head may be checked only 3 edges after the previous issue
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_req <= 1'b0; exp_comp <= 1'b0; exp_ld <= '0;
      exp_mig <= '0; exp_payload <= '0; exp_err <= 1'b0;
      hold_until <= 0;
    end else begin
      exp_req <= 1'b0; exp_comp <= 1'b0; exp_ld <= '0;
      if (edge_cnt >= hold_until && !bus_if.inst_empty &&
          model_ready(bus_if.instruct, bus_if.comp_idle, bus_if.wb_idle, bus_if.ld_idle)) begin
        exp_req     <= 1'b1;
        exp_payload <= bus_if.instruct[INST_LEN-1:OP_W];
        hold_until  <= edge_cnt + 3;
        if (bus_if.instruct[3:0] == 4'd0) begin
          exp_comp <= 1'b1;
        end else if (int'(bus_if.instruct[3:0]) <= NUM_LOAD) begin
          exp_ld  <= 3'(1 << (int'(bus_if.instruct[3:0]) - 1));
          exp_mig <= SEL_W'(bus_if.instruct[3:0]);
        end else if (bus_if.instruct[3:0] != 4'hF) begin
          exp_err <= 1'b1;
        end
      end
    end
    edge_cnt <= edge_cnt + 1;
    if (bus_if.inst_req) rd_ptr <= rd_ptr + 1;
  end

  always @(posedge clk) begin
    #3;
    if (!rst_n) begin
      chk("rst_inst_req", bus_if.inst_req, 0);
      chk("rst_comp_conf", bus_if.comp_conf, 0);
      chk("rst_ld_conf", bus_if.ld_conf, 0);
      chk("rst_mig_sel", bus_if.mig_sel, 0);
      chk("rst_payload", bus_if.payload, 0);
      chk("rst_err", bus_if.err_illegal, 0);
      chk("rst_busy", bus_if.busy, !bus_if.inst_empty);
    end else begin
      chk("inst_req", bus_if.inst_req, exp_req);
      chk("comp_conf", bus_if.comp_conf, exp_comp);
      chk("ld_conf", bus_if.ld_conf, exp_ld);
      chk("mig_sel", bus_if.mig_sel, exp_mig);
      chk("payload", bus_if.payload, exp_payload);
      chk("err_illegal", bus_if.err_illegal, exp_err);
      chk("busy", bus_if.busy, (edge_cnt < hold_until) || !bus_if.inst_empty);
    end
    if (bus_if.inst_req)  req_count++;
    if (bus_if.comp_conf) comp_count++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [INST_LEN-1:0] w);
    fifo_mem[wr_ptr[3:0]] = w;
    wr_ptr++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) fifo_mem[i] = '0;
    bus_if.comp_idle = 1'b1;
    bus_if.wb_idle   = 1'b1;
    bus_if.ld_idle   = 3'b111;
    tick(3);
    chk("reset_req", bus_if.inst_req, 0);
    chk("reset_ld_conf", bus_if.ld_conf, 0);
    chk("reset_mig", bus_if.mig_sel, 0);
    chk("reset_busy", bus_if.busy, 0);
    rst_n = 1'b1;
    tick(2);

    // load channel 1 (opcode 2), all idle
    push({{27{8'hA5}}, 4'h2});
    tick(1);
    chk("ld2_conf", bus_if.ld_conf, 3'b010);
    chk("ld2_req", bus_if.inst_req, 1);
    chk("ld2_mig", bus_if.mig_sel, 2);
    chk("ld2_payload", bus_if.payload, {27{8'hA5}});
    tick(1);
    chk("ld2_req_one_cycle", bus_if.inst_req, 0);
    chk("ld2_conf_one_cycle", bus_if.ld_conf, 0);
    tick(1);

    // serial load: opcode 1 waits for every load channel
    bus_if.ld_idle = 3'b101;
    push({{27{8'h3C}}, 4'h1});
    tick(6);
    chk("serial_stall", req_count, 1);
    bus_if.ld_idle = 3'b111;
    tick(1);
    chk("serial_issue_req", bus_if.inst_req, 1);
    chk("serial_issue_conf", bus_if.ld_conf, 3'b001);
    tick(2);

    // compute with dep=100 blocked by channel 2
    bus_if.ld_idle = 3'b011;
    push({{26{8'h5A}}, 4'h0, 4'h4, 4'h0});
    tick(10);
    chk("dep_stall", comp_count, 0);
    bus_if.ld_idle = 3'b111;
    tick(1);
    chk("dep_issue", bus_if.comp_conf, 1);
    chk("dep_mig_held", bus_if.mig_sel, 1);
    chk("dep_payload", bus_if.payload, {{26{8'h5A}}, 4'h0, 4'h4});
    tick(2);

    // compute with wb_flag waits on write-back
    bus_if.wb_idle = 1'b0;
    push({{26{8'h11}}, 4'h0, 4'h8, 4'h0});
    tick(6);
    chk("wb_stall", comp_count, 1);
    bus_if.wb_idle = 1'b1;
    tick(1);
    chk("wb_issue", bus_if.comp_conf, 1);
    tick(2);

    // barrier waits for compute idle, then pops without conf
    bus_if.comp_idle = 1'b0;
    push({{27{8'hC3}}, 4'hF});
    tick(6);
    chk("bar_stall", req_count, 4);
    bus_if.comp_idle = 1'b1;
    tick(1);
    chk("bar_req", bus_if.inst_req, 1);
    chk("bar_no_comp", bus_if.comp_conf, 0);
    chk("bar_no_ld", bus_if.ld_conf, 0);
    tick(2);

    // illegal opcode 9: popped, sticky error
    push({{27{8'h77}}, 4'h9});
    tick(1);
    chk("ill_req", bus_if.inst_req, 1);
    chk("ill_no_conf", {bus_if.comp_conf, bus_if.ld_conf}, 0);
    chk("ill_err", bus_if.err_illegal, 1);
    tick(2);
    push({{27{8'h00}}, 4'h0});
    tick(4);
    chk("ill_err_sticky", bus_if.err_illegal, 1);
    chk("ill_total_req", req_count, 7);

    // reset during ISSUE aborts; head re-issues after release
    push({{27{8'h2B}}, 4'h3});
    tick(1);
    chk("abort_pre_req", bus_if.inst_req, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_req", bus_if.inst_req, 0);
    chk("abort_ld_conf", bus_if.ld_conf, 0);
    chk("abort_err", bus_if.err_illegal, 0);
    chk("abort_mig", bus_if.mig_sel, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("reissue_conf", bus_if.ld_conf, 3'b100);
    chk("reissue_mig", bus_if.mig_sel, 3);
    chk("reissue_payload", bus_if.payload, {27{8'h2B}});
    tick(3);
    chk("fifo_pops", rd_ptr, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
